// File: rtl/tick_bcd_level_counter_pkg.sv
// Shared types and defaults for the tick-driven BCD counter with level tracking.
package tick_bcd_level_counter_pkg;

  typedef logic [3:0] bcdDigit_t;

  typedef enum logic [1:0] {
    RUN   = 2'd0,
    PAUSE = 2'd1,
    DONE  = 2'd2
  } state_t;

  localparam int LEVEL_STEP_DEF = 10;
  localparam int MAX_LEVEL_DEF  = 10;
  localparam int STEP_W         = 14;

  // Saturating guard (>=) keeps a digit legal even if it ever held 0xA-0xF.
  function automatic bcdDigit_t bcdInc(input bcdDigit_t d);
    return (d >= 4'd9) ? 4'd0 : d + 4'd1;
  endfunction

endpackage

// File: rtl/tick_bcd_level_counter_if.sv
// Control inputs and registered status outputs of the BCD level counter.
interface tick_bcd_level_counter_if;

  logic        TickIn;
  logic        Enable;
  logic        Clear;
  logic [15:0] Digits;
  logic [3:0]  Level;
  logic        Wrap;
  logic        Done;

  modport master (
    output TickIn, Enable, Clear,
    input  Digits, Level, Wrap, Done
  );

  modport slave (
    input  TickIn, Enable, Clear,
    output Digits, Level, Wrap, Done
  );

endinterface

// File: rtl/tick_bcd_level_counter_bcd_digit.sv
// One decade of the BCD chain; carry_out is combinational so the whole chain
// settles within the cycle of the counted tick.
module bcd_digit
  import tick_bcd_level_counter_pkg::*;
(
  input  logic      Clk,
  input  logic      Rst,
  input  logic      inc,
  input  logic      clr,
  output bcdDigit_t value,
  output logic      carry_out
);

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      value <= '0;
    end else if (clr) begin
      value <= '0;
    end else if (inc) begin
      value <= bcdInc(value);
    end
  end

  assign carry_out = inc && (value == 4'd9);

endmodule

// File: rtl/tick_bcd_level_counter.sv
// Counts rising edges of TickIn as a 4-digit BCD value and raises Level every
// LEVEL_STEP counted ticks; optionally halts in DONE on the 9999->0000 rollover.
//
// state | meaning
// RUN   | rising TickIn edges are counted
// PAUSE | Enable low, ticks ignored (also the state after reset)
// DONE  | rollover seen with STOP_AT_WRAP set; only Clear or reset leave it
module tick_bcd_level_counter
  import tick_bcd_level_counter_pkg::*;
#(
  parameter int LEVEL_STEP   = LEVEL_STEP_DEF,
  parameter int MAX_LEVEL    = MAX_LEVEL_DEF,
  parameter bit STOP_AT_WRAP = 1'b0
) (
  input logic                      Clk,
  input logic                      Rst,
  tick_bcd_level_counter_if.slave  bus
);

  localparam logic [STEP_W-1:0] STEP_LAST = STEP_W'(LEVEL_STEP - 1);
  localparam logic [3:0]        LEVEL_SAT = 4'(MAX_LEVEL);

  state_t              state;
  logic                tickPrev;
  logic                tickEvent;
  logic                countTick;
  logic [STEP_W-1:0]   stepCnt;
  logic [4:0]          carry;
  bcdDigit_t [3:0]     digitVal;

  // TickIn is sampled as data; its edge register runs unconditionally.
  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      tickPrev <= 1'b0;
    end else begin
      tickPrev <= bus.TickIn;
    end
  end

  assign tickEvent = bus.TickIn && !tickPrev;
  assign countTick = tickEvent && (state == RUN) && !bus.Clear;
  assign carry[0]  = countTick;

  generate
    for (genvar g = 0; g < 4; g++) begin : gDigit
      bcd_digit uDigit (
        .Clk       (Clk),
        .Rst       (Rst),
        .inc       (carry[g]),
        .clr       (bus.Clear),
        .value     (digitVal[g]),
        .carry_out (carry[g+1])
      );
    end
  endgenerate

  assign bus.Digits = digitVal;

  always_ff @(posedge Clk or negedge Rst) begin
    if (!Rst) begin
      state     <= PAUSE;
      stepCnt   <= '0;
      bus.Level <= '0;
      bus.Wrap  <= 1'b0;
      bus.Done  <= 1'b0;
    end else if (bus.Clear) begin
      state     <= bus.Enable ? RUN : PAUSE;
      stepCnt   <= '0;
      bus.Level <= '0;
      bus.Wrap  <= 1'b0;
      bus.Done  <= 1'b0;
    end else begin
      bus.Wrap <= carry[4];

      // Step counter keeps cycling once Level has saturated.
      if (countTick) begin
        if (stepCnt == STEP_LAST) begin
          stepCnt <= '0;
          if (bus.Level < LEVEL_SAT) begin
            bus.Level <= bus.Level + 4'd1;
          end
        end else begin
          stepCnt <= stepCnt + 1'b1;
        end
      end

      unique case (state)
        RUN: begin
          if (carry[4] && STOP_AT_WRAP) begin
            state    <= DONE;
            bus.Done <= 1'b1;
          end else if (!bus.Enable) begin
            state <= PAUSE;
          end
        end
        PAUSE: begin
          if (bus.Enable) begin
            state <= RUN;
          end
        end
        DONE: begin
          state <= DONE;
        end
        default: begin
          state <= PAUSE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_tick_bcd_level_counter.sv
// Drives two counter instances (free-running and stop-at-wrap) with the same
// stimulus and compares both against an arithmetic model of count, ticks and mode.
module tb_tick_bcd_level_counter;

  logic Clk;
  logic Rst;

  tick_bcd_level_counter_if busA ();
  tick_bcd_level_counter_if busB ();

  tick_bcd_level_counter dutA (
    .Clk (Clk),
    .Rst (Rst),
    .bus (busA.slave)
  );

  tick_bcd_level_counter #(
    .LEVEL_STEP   (10),
    .MAX_LEVEL    (3),
    .STOP_AT_WRAP (1'b1)
  ) dutB (
    .Clk (Clk),
    .Rst (Rst),
    .bus (busB.slave)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  localparam int M_RUN   = 0;
  localparam int M_PAUSE = 1;
  localparam int M_DONE  = 2;

  int vectors     = 0;
  int miscompares = 0;

  // Model: decimal count, total counted ticks since clear/reset, mode.
  int   mCount [2];
  int   mTicks [2];
  int   mMode  [2];
  logic mPrev  [2];
  logic mWrap  [2];

  logic [21:0] obs [2];
  assign obs[0] = {busA.Digits, busA.Level, busA.Wrap, busA.Done};
  assign obs[1] = {busB.Digits, busB.Level, busB.Wrap, busB.Done};

  function automatic int maxLvl(input int i);
    return (i == 0) ? 10 : 3;
  endfunction

  function automatic logic [21:0] expOf(input int i);
    int lv;
    logic [15:0] d;
    lv = mTicks[i] / 10;
    if (lv > maxLvl(i)) lv = maxLvl(i);
    d = {4'(mCount[i] / 1000 % 10), 4'(mCount[i] / 100 % 10),
         4'(mCount[i] / 10 % 10), 4'(mCount[i] % 10)};
    return {d, 4'(lv), mWrap[i], (mMode[i] == M_DONE)};
  endfunction

  task automatic modelReset();
    for (int i = 0; i < 2; i++) begin
      mCount[i] = 0;
      mTicks[i] = 0;
      mMode[i]  = M_PAUSE;
      mPrev[i]  = 1'b0;
      mWrap[i]  = 1'b0;
    end
  endtask

  task automatic modelStep(input int i, input logic t, input logic en, input logic clr);
    logic ev;
    ev = t && !mPrev[i];
    mPrev[i] = t;
    mWrap[i] = 1'b0;
    if (clr) begin
      mCount[i] = 0;
      mTicks[i] = 0;
      mMode[i]  = en ? M_RUN : M_PAUSE;
    end else if (mMode[i] == M_RUN) begin
      if (ev) begin
        mTicks[i]++;
        if (mCount[i] == 9999) begin
          mCount[i] = 0;
          mWrap[i]  = 1'b1;
        end else begin
          mCount[i]++;
        end
      end
      if (mWrap[i] && i == 1) mMode[i] = M_DONE;
      else if (!en) mMode[i] = M_PAUSE;
    end else if (mMode[i] == M_PAUSE) begin
      if (en) mMode[i] = M_RUN;
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic t, input logic en, input logic clr);
    busA.TickIn = t;  busA.Enable = en;  busA.Clear = clr;
    busB.TickIn = t;  busB.Enable = en;  busB.Clear = clr;
    @(posedge Clk);
    for (int i = 0; i < 2; i++) modelStep(i, t, en, clr);
    @(negedge Clk);
  endtask

  task automatic tick(input logic en);
    step(1'b1, en, 1'b0);
    step(1'b0, en, 1'b0);
  endtask

  task automatic test_reset();
    Rst = 1'b0;
    busA.TickIn = 1'b0;  busA.Enable = 1'b0;  busA.Clear = 1'b0;
    busB.TickIn = 1'b0;  busB.Enable = 1'b0;  busB.Clear = 1'b0;
    modelReset();
    repeat (3) @(negedge Clk);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i] !== 22'h0 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL reset inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
    Rst = 1'b1;
  endtask

  task automatic test_basic();
    logic wrapSeen;
    wrapSeen = 1'b0;
    step(1'b0, 1'b1, 1'b0);
    for (int k = 0; k < 3; k++) begin
      step(1'b1, 1'b1, 1'b0);
      wrapSeen |= busA.Wrap | busB.Wrap;
      step(1'b0, 1'b1, 1'b0);
      wrapSeen |= busA.Wrap | busB.Wrap;
    end
    vectors++;
    if (wrapSeen !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_wrap: got %b want 0", wrapSeen);
    end
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i] !== expOf(i) || obs[i][21:2] !== {16'h0003, 4'd0}) begin
        miscompares++;
        $display("FAIL basic_count inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
  endtask

  task automatic test_bcd_carry();
    repeat (6) tick(1'b1);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i][21:6] !== 16'h0009 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL carry_0009 inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
    tick(1'b1);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i][21:6] !== 16'h0010 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL carry_0010 inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
    for (int k = 0; k < 989; k++) begin
      tick(1'b1);
      for (int n = 0; n < 4; n++) begin
        vectors++;
        if (obs[0][6+4*n +: 4] > 4'd9) begin
          miscompares++;
          $display("FAIL digit_legal nibble%0d: got %h want <=9", n, obs[0][6+4*n +: 4]);
        end
      end
    end
    tick(1'b1);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i][21:6] !== 16'h1000 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL carry_1000 inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
  endtask

  task automatic test_enable_pause();
    logic [15:0] saved;
    saved = busA.Digits;
    step(1'b0, 1'b0, 1'b0);
    repeat (5) tick(1'b0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i][21:6] !== saved || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL pause_hold inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_level();
    step(1'b0, 1'b1, 1'b1);
    repeat (25) tick(1'b1);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i][5:2] !== 4'd2 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL level_25 inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
    repeat (75) tick(1'b1);
    vectors++;
    if (busA.Level !== 4'd10 || obs[0] !== expOf(0)) begin
      miscompares++;
      $display("FAIL level_100_max10: got %0d want 10", busA.Level);
    end
    vectors++;
    if (busB.Level !== 4'd3 || obs[1] !== expOf(1)) begin
      miscompares++;
      $display("FAIL level_100_max3: got %0d want 3", busB.Level);
    end
  endtask

  task automatic test_clear_tick();
    step(1'b0, 1'b1, 1'b1);
    repeat (42) tick(1'b1);
    vectors++;
    if ({busA.Digits, busA.Level} !== {16'h0042, 4'd4}) begin
      miscompares++;
      $display("FAIL clear_pre: got %h/%0d want 0042/4", busA.Digits, busA.Level);
    end
    step(1'b1, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i] !== 22'h0 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL clear_tick inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
    step(1'b0, 1'b1, 1'b0);
  endtask

  task automatic test_random();
    logic t, en, clr;
    for (int k = 0; k < 400; k++) begin
      t   = 1'($urandom_range(0, 1));
      en  = ($urandom_range(0, 7) != 0);
      clr = ($urandom_range(0, 31) == 0);
      step(t, en, clr);
      for (int i = 0; i < 2; i++) begin
        vectors++;
        if (obs[i] !== expOf(i)) begin
          miscompares++;
          $display("FAIL random inst%0d step%0d: got %h want %h", i, k, obs[i], expOf(i));
        end
      end
    end
  endtask

  task automatic test_wrap();
    step(1'b0, 1'b1, 1'b1);
    repeat (9999) tick(1'b1);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i][21:6] !== 16'h9999 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL wrap_pre inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
    step(1'b1, 1'b1, 1'b0);
    vectors++;
    if (obs[0] !== {16'h0000, 4'd10, 1'b1, 1'b0} || obs[0] !== expOf(0)) begin
      miscompares++;
      $display("FAIL wrap_run: got %h want %h", obs[0], expOf(0));
    end
    vectors++;
    if (obs[1] !== {16'h0000, 4'd3, 1'b1, 1'b1} || obs[1] !== expOf(1)) begin
      miscompares++;
      $display("FAIL wrap_stop: got %h want %h", obs[1], expOf(1));
    end
    step(1'b0, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i][1] !== 1'b0 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL wrap_pulse inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
    repeat (3) tick(1'b1);
    step(1'b0, 1'b0, 1'b0);
    tick(1'b1);
    vectors++;
    if ({busB.Digits, busB.Done} !== {16'h0000, 1'b1} || obs[1] !== expOf(1)) begin
      miscompares++;
      $display("FAIL done_hold: got %h want %h", obs[1], expOf(1));
    end
    vectors++;
    if (obs[0] !== expOf(0)) begin
      miscompares++;
      $display("FAIL after_wrap_run: got %h want %h", obs[0], expOf(0));
    end
    step(1'b0, 1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i] !== 22'h0 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL done_clear inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
  endtask

  task automatic test_async_reset();
    step(1'b0, 1'b1, 1'b0);
    repeat (17) tick(1'b1);
    #2 Rst = 1'b0;
    modelReset();
    #1;
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i] !== 22'h0 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL async_reset inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
    #1 Rst = 1'b1;
    step(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i] !== 22'h0 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL release_tick inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
    step(1'b0, 1'b1, 1'b0);
    tick(1'b1);
    for (int i = 0; i < 2; i++) begin
      vectors++;
      if (obs[i][21:6] !== 16'h0001 || obs[i] !== expOf(i)) begin
        miscompares++;
        $display("FAIL post_reset inst%0d: got %h want %h", i, obs[i], expOf(i));
      end
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_bcd_carry();
    test_enable_pause();
    test_level();
    test_clear_tick();
    test_random();
    test_wrap();
    test_async_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/tick_bcd_level_counter.md
TICK_BCD_LEVEL_COUNTER -- requirements
Module: tick_bcd_level_counter

Interface
REQ-001 Parameter LEVEL_STEP, default 10: number of counted ticks per level increment; legal range 1..9999.
REQ-002 Parameter MAX_LEVEL, default 10: saturation value of Level; legal range 0..15.
REQ-003 Parameter STOP_AT_WRAP, default 0: 1 means enter DONE on 9999->0000 rollover; 0 means keep running.
REQ-004 Clk  input  1  system clock; all state updates on posedge Clk.
REQ-005 Rst  input  1  reset, asynchronous assert, active-low (0 = reset).
REQ-006 TickIn  input  1  divided-clock level from the rate divider, synchronous to Clk.
REQ-007 Enable  input  1  1 = count ticks; 0 = pause.
REQ-008 Clear  input  1  synchronous clear of count, level and state.
REQ-009 Digits  output  16  four BCD digits; [15:12] thousands ... [3:0] units.
REQ-010 Level  output  4  current level; feeds the divider rate-select input directly.
REQ-011 Wrap  output  1  one-cycle pulse on 9999->0000 rollover.
REQ-012 Done  output  1  high while in state DONE.

Function
REQ-013 Tick event: TickIn==1 and the registered previous TickIn==0; the edge register updates every cycle regardless of state, Enable or Clear.
REQ-014 States: RUN, PAUSE, DONE; Done = (state==DONE).
REQ-015 RUN -> PAUSE when Enable==0; PAUSE -> RUN when Enable==1; each transition takes one cycle, and a tick in the transition cycle is evaluated against the current state.
REQ-016 Ticks are counted only in RUN with Clear==0; a counted tick updates Digits on the same clock edge (Digits changes 1 cycle after the TickIn rising edge is sampled).
REQ-017 Increment: BCD add 1 with per-digit carry; a digit at 9 becomes 0 and carries; no digit ever holds 0xA-0xF.
REQ-018 9999 + tick -> 0000 and Wrap=1 for exactly that cycle; with STOP_AT_WRAP=1, also go to DONE.
REQ-019 DONE ignores ticks and Enable; leave DONE only via Clear or reset.
REQ-020 An internal binary step counter (14 bits) increments on each counted tick; when it reaches LEVEL_STEP it returns to 0 and Level increments in the same cycle.
REQ-021 Level saturates at MAX_LEVEL; the step counter keeps cycling at saturation.
REQ-022 Rollover does not reset Level or the step counter.
REQ-023 Clear==1 (any state): next cycle Digits=0, Level=0, step counter=0, Wrap=0, state=RUN if Enable==1 else PAUSE; Clear has priority over a simultaneous tick, which is discarded.
REQ-024 All outputs are registered; no combinational path from inputs to outputs.

Reset
REQ-025 Rst==0 asynchronously forces Digits=16'h0000, Level=0, Wrap=0, Done=0, step counter=0, previous-TickIn register=0, state=PAUSE.
REQ-026 After Rst deasserts, state enters RUN on the first edge with Enable==1; a TickIn already high at release produces a tick event on the first clock (prev=0), and it is counted only if the state is already RUN.
REQ-027 Reset asserted mid-count drops all progress; nothing is retained.

Structure
REQ-028 Shared package holds: BCD digit type (4 bits), state enum {RUN, PAUSE, DONE}, default constants LEVEL_STEP_DEF=10 and MAX_LEVEL_DEF=10.
REQ-029 One sub-module, bcd_digit: a decade counter with inputs inc and clr and outputs value[3:0] and carry_out (value==9 && inc), instantiated four times and chained by carry.
REQ-030 Target size is 120-400 lines of RTL, with no clock gating and no derived clocks (TickIn is treated as data, not as a clock).

Verification
REQ-031 Rst low, then release with Enable=1 and 3 TickIn rising edges -> Digits=16'h0003, Level=0, Wrap never high.
REQ-032 Preload by ticking to 0009, then one tick -> 0010; from 0999, one tick -> 1000, with every digit at 0-9 throughout.
REQ-033 From 9999 with STOP_AT_WRAP=0, one tick -> 0000 with a 1-cycle Wrap pulse; with STOP_AT_WRAP=1, Done=1 and further ticks leave Digits at 0000.
REQ-034 LEVEL_STEP=10, 25 ticks -> Level=2; MAX_LEVEL=3, 100 ticks -> Level=3 (saturated).
REQ-035 Enable=0 during 5 ticks -> Digits unchanged; Clear asserted in the same cycle as a tick at 0042/Level 4 -> next cycle 0000/Level 0.
REQ-036 Rst pulsed low for less than one clock period between edges mid-count -> outputs 0 immediately, before the next Clk edge.
